counter_sched: RTL and testbench

// Command scheduler for the 10-bit LED counter datapath. Shares the counter register between five

---
 rtl/counter_sched.sv | 169 ++++++++++++++++
 tb/tb_counter_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: fixed-priority scheduler that shares the LED counter register
// between clear, two preset loads, a manual step and a periodic auto-tick.
// One command is in flight at a time over a valid/ready handshake.
module counter_sched #(
    parameter int unsigned TICK_LEN = 4194304
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [1:0] MODE,
    input  logic       AUTO,
    output logic       CMD_VALID,
    output logic [2:0] CMD_OP,
    input  logic       CMD_READY,
    output logic [2:0] GRANT_ID,
    output logic       DROP,
    output logic [4:0] PENDING
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b000;
    localparam logic [2:0] OP_LOAD_A = 3'b001;
    localparam logic [2:0] OP_LOAD_B = 3'b010;
    localparam logic [2:0] OP_INC    = 3'b011;
    localparam logic [2:0] OP_DEC    = 3'b100;
    localparam logic [2:0] OP_SHL    = 3'b101;

    localparam logic [23:0] TICK_LAST = 24'(TICK_LEN - 1);

    state_t      state_q, state_d;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]  pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  gid_q, gid_d;
    logic        drop_q, drop_d;

    logic        tick_fire;
    logic [4:0]  set_vec;
    logic [4:0]  grant_oh;
    logic [4:0]  clr_mask;
    logic        grant_vld;
    logic [2:0]  grant_idx;
    logic [2:0]  step_op;
    logic        step_ok;

    // Auto-tick divider: free-runs while enabled, held at zero otherwise.
    always_comb begin
        tick_cnt_d = '0;
        tick_fire  = 1'b0;
        if (AUTO) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_fire = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 24'd1;
            end
        end
    end

    // Priority pick, pending-bit update and lost-request detection.
    always_comb begin
        set_vec   = {tick_fire, REQ};
        grant_oh  = '0;
        grant_idx = 3'd0;
        grant_vld = 1'b0;
        if (state_q == IDLE) begin
            for (int i = 4; i >= 0; i--) begin
                if (pend_q[i]) begin
                    grant_oh  = 5'b00001 << i;
                    grant_idx = 3'(i);
                    grant_vld = 1'b1;
                end
            end
        end
        // A granted clear makes any queued step/tick obsolete.
        clr_mask = grant_oh;
        if (grant_oh[0]) begin
            clr_mask[4:3] = 2'b11;
        end
        pend_d = (pend_q & ~clr_mask) | set_vec;
        // A request is lost only if its bit was still outstanding afterwards.
        drop_d = |(set_vec & pend_q & ~clr_mask);
    end

    // Translate the step mode into a datapath opcode; mode 11 means no-op.
    always_comb begin
        step_op = OP_INC;
        step_ok = 1'b1;
        case (MODE)
            2'b00:   step_op = OP_INC;
            2'b01:   step_op = OP_DEC;
            2'b10:   step_op = OP_SHL;
            default: step_ok = 1'b0;
        endcase
    end

    // Issue FSM next-state: grant from IDLE, wait for the handshake in ISSUE.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        op_d    = op_q;
        gid_d   = gid_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    if (grant_idx >= 3'd3) begin
                        if (step_ok) begin
                            op_d    = step_op;
                            gid_d   = grant_idx;
                            valid_d = 1'b1;
                            state_d = ISSUE;
                        end
                    end else begin
                        case (grant_idx)
                            3'd0:    op_d = OP_CLEAR;
                            3'd1:    op_d = OP_LOAD_A;
                            default: op_d = OP_LOAD_B;
                        endcase
                        gid_d   = grant_idx;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (CMD_READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // All state registers; reset withdraws any outstanding command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            op_q       <= OP_CLEAR;
            gid_q      <= 3'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            gid_q      <= gid_d;
            drop_q     <= drop_d;
        end
    end

    assign CMD_VALID = valid_q;
    assign CMD_OP    = op_q;
    assign GRANT_ID  = gid_q;
    assign DROP      = drop_q;
    assign PENDING   = pend_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus randomized traffic checked
// against a rule-level model of the scheduler.
module tb_counter_sched;

    localparam int TL = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] REQ = 4'd0;
    logic [1:0] MODE = 2'd0;
    logic       AUTO = 1'b0;
    logic       CMD_READY = 1'b0;
    logic       CMD_VALID;
    logic [2:0] CMD_OP;
    logic [2:0] GRANT_ID;
    logic       DROP;
    logic [4:0] PENDING;

    int checks = 0;
    int passes = 0;

    counter_sched #(.TICK_LEN(TL)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .MODE      (MODE),
        .AUTO      (AUTO),
        .CMD_VALID (CMD_VALID),
        .CMD_OP    (CMD_OP),
        .CMD_READY (CMD_READY),
        .GRANT_ID  (GRANT_ID),
        .DROP      (DROP),
        .PENDING   (PENDING)
    );

    always #5 CLK = ~CLK;

    // Reference model: pending set of requests, a "busy" command slot and a tick count.
    logic [4:0] m_pend;
    logic       m_valid;
    logic [2:0] m_op;
    logic [2:0] m_gid;
    logic       m_drop;
    int         m_tick;
    int         mg;
    logic [4:0] m_keep;
    logic [4:0] m_req;
    logic       m_fire;

    always_comb begin
        mg = -1;
        for (int i = 0; i < 5; i++) begin
            if (!m_valid && m_pend[i] && mg < 0) mg = i;
        end
        m_keep = m_pend;
        if (mg >= 0) begin
            m_keep[mg] = 1'b0;
            if (mg == 0) m_keep[4:3] = 2'b00;
        end
        m_fire = AUTO && (m_tick == TL - 1);
        m_req  = {m_fire, REQ};
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_op    <= 3'd0;
            m_gid   <= 3'd0;
            m_drop  <= 1'b0;
            m_tick  <= 0;
        end else begin
            m_drop <= |(m_req & m_keep);
            m_pend <= m_keep | m_req;
            m_tick <= (!AUTO || m_fire) ? 0 : m_tick + 1;
            if (m_valid) begin
                if (CMD_READY) m_valid <= 1'b0;
            end else if (mg >= 0) begin
                if (mg < 3) begin
                    m_valid <= 1'b1;
                    m_op    <= 3'(mg);
                    m_gid   <= 3'(mg);
                end else if (MODE != 2'b11) begin
                    m_valid <= 1'b1;
                    m_op    <= 3'(3 + int'(MODE));
                    m_gid   <= 3'(mg);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        checks++;
        if ({CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING} !== 13'd0)
            $display("FAIL reset_state: got %b want %b", {CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING}, 13'd0);
        else passes++;
        $display("reset: valid=%b op=%b gid=%0d pend=%b", CMD_VALID, CMD_OP, GRANT_ID, PENDING);
    endtask

    task automatic test_single_load();
        CMD_READY = 1'b1;
        REQ = 4'b0010;
        step();
        REQ = 4'b0000;
        checks++;
        if (PENDING !== 5'b00010 || CMD_VALID !== 1'b0)
            $display("FAIL load_pending: got pend=%b valid=%b want pend=00010 valid=0", PENDING, CMD_VALID);
        else passes++;
        step();
        checks++;
        if (CMD_VALID !== 1'b1 || CMD_OP !== 3'b001 || GRANT_ID !== 3'd1)
            $display("FAIL load_issue: got valid=%b op=%b gid=%0d want 1/001/1", CMD_VALID, CMD_OP, GRANT_ID);
        else passes++;
        step();
        checks++;
        if (CMD_VALID !== 1'b0 || GRANT_ID !== 3'd1 || PENDING !== 5'd0)
            $display("FAIL load_done: got valid=%b gid=%0d pend=%b want 0/1/00000", CMD_VALID, GRANT_ID, PENDING);
        else passes++;
        $display("single_load: op=%b gid=%0d", CMD_OP, GRANT_ID);
    endtask

    task automatic test_all_requests();
        logic [2:0] ops[$];
        CMD_READY = 1'b1;
        REQ = 4'b1111;
        step();
        REQ = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step();
            if (CMD_VALID) ops.push_back(CMD_OP);
        end
        checks++;
        if (ops.size() != 3 || ops[0] !== 3'b000 || ops[1] !== 3'b001 || ops[2] !== 3'b010)
            $display("FAIL all_req_order: got %0d ops %p want 000,001,010", ops.size(), ops);
        else passes++;
        checks++;
        if (PENDING !== 5'd0 || DROP !== 1'b0)
            $display("FAIL all_req_pending: got pend=%b drop=%b want 00000/0", PENDING, DROP);
        else passes++;
        $display("all_requests: %0d commands issued", ops.size());
    endtask

    task automatic test_auto_tick();
        int n;
        logic [12:0] exp;
        CMD_READY = 1'b1;
        MODE = 2'b01;
        AUTO = 1'b1;
        n = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            exp = {m_valid, m_op, m_gid, m_drop, m_pend};
            checks++;
            if ({CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING} !== exp)
                $display("FAIL tick_cycle%0d: got %b want %b", i, {CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING}, exp);
            else passes++;
            if (CMD_VALID && CMD_OP == 3'b100 && GRANT_ID == 3'd4) n++;
        end
        checks++;
        if (n != 4) $display("FAIL tick_dec_count: got %0d want 4", n);
        else passes++;
        $display("auto_tick dec: %0d commands", n);
        AUTO = 1'b0;
        step();
        MODE = 2'b11;
        AUTO = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (CMD_VALID) n++;
        end
        checks++;
        if (n != 0) $display("FAIL tick_hold_count: got %0d want 0", n);
        else passes++;
        $display("auto_tick hold: %0d commands", n);
        AUTO = 1'b0;
        step();
        step();
    endtask

    task automatic test_drop();
        CMD_READY = 1'b0;
        MODE = 2'b00;
        REQ = 4'b0010;
        step();
        REQ = 4'b0000;
        step();
        REQ = 4'b1000;
        step();
        checks++;
        if (DROP !== 1'b0 || PENDING !== 5'b01000)
            $display("FAIL drop_first: got drop=%b pend=%b want 0/01000", DROP, PENDING);
        else passes++;
        step();
        REQ = 4'b0000;
        checks++;
        if (DROP !== 1'b1 || CMD_VALID !== 1'b1 || CMD_OP !== 3'b001)
            $display("FAIL drop_second: got drop=%b valid=%b op=%b want 1/1/001", DROP, CMD_VALID, CMD_OP);
        else passes++;
        step();
        checks++;
        if (DROP !== 1'b0 || CMD_OP !== 3'b001)
            $display("FAIL drop_pulse: got drop=%b op=%b want 0/001", DROP, CMD_OP);
        else passes++;
        CMD_READY = 1'b1;
        step();
        step();
        checks++;
        if (CMD_VALID !== 1'b1 || CMD_OP !== 3'b011 || GRANT_ID !== 3'd3)
            $display("FAIL drop_step_issue: got valid=%b op=%b gid=%0d want 1/011/3", CMD_VALID, CMD_OP, GRANT_ID);
        else passes++;
        step();
        $display("drop: step issued op=011 after stall");
    endtask

    task automatic test_reset_during_issue();
        CMD_READY = 1'b0;
        MODE = 2'b00;
        REQ = 4'b0001;
        step();
        REQ = 4'b0000;
        step();
        REQ = 4'b1111;
        AUTO = 1'b1;
        step();
        REQ = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (PENDING !== 5'h1F || CMD_VALID !== 1'b1)
            $display("FAIL rst_issue_setup: got pend=%b valid=%b want 11111/1", PENDING, CMD_VALID);
        else passes++;
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++;
        if (CMD_VALID !== 1'b0 || PENDING !== 5'd0 || DROP !== 1'b0)
            $display("FAIL rst_issue_clear: got valid=%b pend=%b drop=%b want 0/00000/0", CMD_VALID, PENDING, DROP);
        else passes++;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (PENDING[4] !== 1'b0)
            $display("FAIL rst_tick_early: got pend4=%b want 0", PENDING[4]);
        else passes++;
        step();
        checks++;
        if (PENDING !== 5'b10000)
            $display("FAIL rst_tick_restart: got pend=%b want 10000", PENDING);
        else passes++;
        AUTO = 1'b0;
        CMD_READY = 1'b1;
        for (int i = 0; i < 4; i++) step();
        $display("reset_during_issue: tick restarted from zero");
    endtask

    task automatic test_random();
        logic [12:0] exp;
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            REQ[0] = ($urandom_range(0, 7) == 0);
            REQ[1] = ($urandom_range(0, 5) == 0);
            REQ[2] = ($urandom_range(0, 5) == 0);
            REQ[3] = ($urandom_range(0, 3) == 0);
            MODE = 2'($urandom_range(0, 3));
            AUTO = ($urandom_range(0, 4) != 0);
            CMD_READY = ($urandom_range(0, 2) != 0);
            RST = ($urandom_range(0, 79) == 0);
            step();
            exp = {m_valid, m_op, m_gid, m_drop, m_pend};
            checks++;
            if ({CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING} !== exp) begin
                bad++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {CMD_VALID, CMD_OP, GRANT_ID, DROP, PENDING}, exp);
            end else passes++;
        end
        RST = 1'b0;
        REQ = 4'd0;
        AUTO = 1'b0;
        $display("random: 600 cycles, %0d mismatching", bad);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_all_requests();
        test_auto_tick();
        test_drop();
        test_reset_during_issue();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
